// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game body logic.
package snake_pkg;

    // Coordinate and length widths.
    localparam int unsigned X_W   = 7;
    localparam int unsigned Y_W   = 6;
    localparam int unsigned LEN_W = 5;

    // Direction encoding; opposite directions differ only in bit 1.
    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_RIGHT = 2'd1;
    localparam dir_t DIR_DOWN  = 2'd2;
    localparam dir_t DIR_LEFT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DEAD
    } state_t;

    // Direction that would make the snake turn back on itself.
    function automatic dir_t dir_reverse(input dir_t d);
        return d ^ 2'd2;
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// Next head cell for a given direction plus wall detection.
module snake_next_head
    import snake_pkg::*;
#(
    parameter int unsigned GRID_COLS = 64,
    parameter int unsigned GRID_ROWS = 48
) (
    input  logic [X_W-1:0] head_x,
    input  logic [Y_W-1:0] head_y,
    input  dir_t           dir,
    output logic [X_W-1:0] nh_x,
    output logic [Y_W-1:0] nh_y,
    output logic           wall_hit
);

    // One extra bit so that stepping below zero shows up as a negative value.
    logic signed [X_W:0] sx;
    logic signed [Y_W:0] sy;

    // Step one cell in the requested direction and flag anything off the grid.
    always_comb begin
        sx = $signed({1'b0, head_x});
        sy = $signed({1'b0, head_y});
        unique case (dir)
            DIR_UP:    sy = sy - (Y_W + 1)'(1);
            DIR_RIGHT: sx = sx + (X_W + 1)'(1);
            DIR_DOWN:  sy = sy + (Y_W + 1)'(1);
            DIR_LEFT:  sx = sx - (X_W + 1)'(1);
            default:   sx = sx;
        endcase
        nh_x     = sx[X_W-1:0];
        nh_y     = sy[Y_W-1:0];
        // Sign bit set means underflow (or overflow past the top of the range).
        wall_hit = sx[X_W] || (sx[X_W-1:0] >= X_W'(GRID_COLS)) ||
                   sy[Y_W] || (sy[Y_W-1:0] >= Y_W'(GRID_ROWS));
    end

endmodule

// File: rtl/snake_body.sv
// Snake position, segment buffer, steering, growth and collision handling.
module snake_body
    import snake_pkg::*;
#(
    parameter int unsigned GRID_COLS = 64,
    parameter int unsigned GRID_ROWS = 48,
    parameter int unsigned START_X   = 10,
    parameter int unsigned START_Y   = 10,
    parameter int unsigned START_LEN = 3,
    parameter int unsigned MAX_LEN   = 18
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             move_tick,
    input  logic             dir_valid,
    input  logic [1:0]       dir_req,
    input  logic [X_W-1:0]   apple_x,
    input  logic [Y_W-1:0]   apple_y,
    input  logic [X_W-1:0]   query_x,
    input  logic [Y_W-1:0]   query_y,
    output logic [X_W-1:0]   head_x,
    output logic [Y_W-1:0]   head_y,
    output logic [LEN_W-1:0] length,
    output logic             query_hit,
    output logic             step,
    output logic             ate,
    output logic             game_over
);

    state_t           state_q, state_d;
    logic [X_W-1:0]   seg_x_q [MAX_LEN];
    logic [X_W-1:0]   seg_x_d [MAX_LEN];
    logic [Y_W-1:0]   seg_y_q [MAX_LEN];
    logic [Y_W-1:0]   seg_y_d [MAX_LEN];
    logic [LEN_W-1:0] len_q, len_d;
    dir_t             cur_dir_q, cur_dir_d;
    dir_t             pend_dir_q, pend_dir_d;
    logic             step_q, step_d;
    logic             ate_q, ate_d;

    logic [X_W-1:0]   nh_x;
    logic [Y_W-1:0]   nh_y;
    logic             wall_hit;
    logic             eat;
    logic             grow;
    logic             self_hit;

    // Starting body: a horizontal line trailing left from the start cell.
    function automatic logic [X_W-1:0] init_x(input int i);
        if (i < int'(START_LEN)) begin
            return X_W'(int'(START_X) - i);
        end
        return '0;
    endfunction

    function automatic logic [Y_W-1:0] init_y(input int i);
        if (i < int'(START_LEN)) begin
            return Y_W'(START_Y);
        end
        return '0;
    endfunction

    snake_next_head #(
        .GRID_COLS (GRID_COLS),
        .GRID_ROWS (GRID_ROWS)
    ) u_next_head (
        .head_x   (seg_x_q[0]),
        .head_y   (seg_y_q[0]),
        .dir      (pend_dir_q),
        .nh_x     (nh_x),
        .nh_y     (nh_y),
        .wall_hit (wall_hit)
    );

    assign eat  = (nh_x == apple_x) && (nh_y == apple_y);
    assign grow = eat && (len_q < LEN_W'(MAX_LEN));

    // Self collision: the tail cell only counts when it stays put because we grow.
    always_comb begin
        self_hit = 1'b0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if ((seg_x_q[i] == nh_x) && (seg_y_q[i] == nh_y) &&
                (((i + 1) < int'(len_q)) || (grow && ((i + 1) == int'(len_q))))) begin
                self_hit = 1'b1;
            end
        end
    end

    // Renderer lookup over the live segments only.
    always_comb begin
        query_hit = 1'b0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if ((i < int'(len_q)) && (seg_x_q[i] == query_x) && (seg_y_q[i] == query_y)) begin
                query_hit = 1'b1;
            end
        end
    end

    // Game state machine: start/reload, move evaluation and steering.
    always_comb begin
        state_d    = state_q;
        seg_x_d    = seg_x_q;
        seg_y_d    = seg_y_q;
        len_d      = len_q;
        cur_dir_d  = cur_dir_q;
        pend_dir_d = pend_dir_q;
        step_d     = 1'b0;
        ate_d      = 1'b0;
        unique case (state_q)
            IDLE, DEAD: begin
                if (start) begin
                    for (int i = 0; i < int'(MAX_LEN); i++) begin
                        seg_x_d[i] = init_x(i);
                        seg_y_d[i] = init_y(i);
                    end
                    len_d      = LEN_W'(START_LEN);
                    cur_dir_d  = DIR_RIGHT;
                    pend_dir_d = DIR_RIGHT;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (move_tick) begin
                    cur_dir_d = pend_dir_q;
                    if (wall_hit || self_hit) begin
                        state_d = DEAD;
                    end else begin
                        for (int i = int'(MAX_LEN) - 1; i > 0; i--) begin
                            seg_x_d[i] = seg_x_q[i-1];
                            seg_y_d[i] = seg_y_q[i-1];
                        end
                        seg_x_d[0] = nh_x;
                        seg_y_d[0] = nh_y;
                        len_d      = len_q + LEN_W'(grow);
                        step_d     = 1'b1;
                        ate_d      = eat;
                    end
                end
                // Checked against the committed direction so a same-cycle tick
                // still consumes the old request and this one waits for the next move.
                if (dir_valid && (dir_req != dir_reverse(cur_dir_q))) begin
                    pend_dir_d = dir_req;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous reset to the starting snake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            len_q      <= LEN_W'(START_LEN);
            cur_dir_q  <= DIR_RIGHT;
            pend_dir_q <= DIR_RIGHT;
            step_q     <= 1'b0;
            ate_q      <= 1'b0;
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= init_y(i);
            end
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cur_dir_q  <= cur_dir_d;
            pend_dir_q <= pend_dir_d;
            step_q     <= step_d;
            ate_q      <= ate_d;
            seg_x_q    <= seg_x_d;
            seg_y_q    <= seg_y_d;
        end
    end

    assign head_x    = seg_x_q[0];
    assign head_y    = seg_y_q[0];
    assign length    = len_q;
    assign step      = step_q;
    assign ate       = ate_q;
    assign game_over = (state_q == DEAD);

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: four instances with different start/max lengths.
module tb_snake_body;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       move_tick;
    logic       dir_valid;
    logic [1:0] dir_req;
    logic [6:0] apple_x;
    logic [5:0] apple_y;
    logic [6:0] query_x;
    logic [5:0] query_y;

    // Index 0 default, 1 START_LEN=5, 2 START_LEN=4, 3 MAX_LEN=4.
    logic [6:0] hx  [4];
    logic [5:0] hy  [4];
    logic [4:0] len [4];
    logic       qh  [4];
    logic       stp [4];
    logic       at  [4];
    logic       go  [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int rst, st, tk, dv, dr;
        int ax, ay, qx, qy, qh;
        int hx, hy, len, stp, at, go;
    } vec_t;

    vec_t vq [$];

    snake_body u_dflt (
        .clk (clk), .reset_n (reset_n), .start (start), .move_tick (move_tick),
        .dir_valid (dir_valid), .dir_req (dir_req), .apple_x (apple_x), .apple_y (apple_y),
        .query_x (query_x), .query_y (query_y), .head_x (hx[0]), .head_y (hy[0]),
        .length (len[0]), .query_hit (qh[0]), .step (stp[0]), .ate (at[0]), .game_over (go[0])
    );

    snake_body #(.START_LEN (5)) u_l5 (
        .clk (clk), .reset_n (reset_n), .start (start), .move_tick (move_tick),
        .dir_valid (dir_valid), .dir_req (dir_req), .apple_x (apple_x), .apple_y (apple_y),
        .query_x (query_x), .query_y (query_y), .head_x (hx[1]), .head_y (hy[1]),
        .length (len[1]), .query_hit (qh[1]), .step (stp[1]), .ate (at[1]), .game_over (go[1])
    );

    snake_body #(.START_LEN (4)) u_l4 (
        .clk (clk), .reset_n (reset_n), .start (start), .move_tick (move_tick),
        .dir_valid (dir_valid), .dir_req (dir_req), .apple_x (apple_x), .apple_y (apple_y),
        .query_x (query_x), .query_y (query_y), .head_x (hx[2]), .head_y (hy[2]),
        .length (len[2]), .query_hit (qh[2]), .step (stp[2]), .ate (at[2]), .game_over (go[2])
    );

    snake_body #(.MAX_LEN (4)) u_m4 (
        .clk (clk), .reset_n (reset_n), .start (start), .move_tick (move_tick),
        .dir_valid (dir_valid), .dir_req (dir_req), .apple_x (apple_x), .apple_y (apple_y),
        .query_x (query_x), .query_y (query_y), .head_x (hx[3]), .head_y (hy[3]),
        .length (len[3]), .query_hit (qh[3]), .step (stp[3]), .ate (at[3]), .game_over (go[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock with the given strobes, then sample 1 time unit after the edge.
    task automatic cyc(input int st, input int tk, input int dv, input int dr);
        start     = (st != 0);
        move_tick = (tk != 0);
        dir_valid = (dv != 0);
        dir_req   = 2'(dr);
        @(posedge clk);
        #1;
        start     = 1'b0;
        move_tick = 1'b0;
        dir_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        #1;
    endtask

    // Request a direction, tick, then leave the spacing the design needs.
    task automatic turn_and_tick(input int dr);
        cyc(0, 0, 1, dr);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
    endtask

    function automatic vec_t mk(input int rst, st, tk, dv, dr, ax, ay, qx, qy, qh,
                                input int hx_e, hy_e, len_e, stp_e, at_e, go_e);
        vec_t v;
        v.rst = rst; v.st = st; v.tk = tk; v.dv = dv; v.dr = dr;
        v.ax = ax; v.ay = ay; v.qx = qx; v.qy = qy; v.qh = qh;
        v.hx = hx_e; v.hy = hy_e; v.len = len_e; v.stp = stp_e; v.at = at_e; v.go = go_e;
        return v;
    endfunction

    initial begin
        vec_t v;
        reset_n   = 1'b0;
        start     = 1'b0;
        move_tick = 1'b0;
        dir_valid = 1'b0;
        dir_req   = 2'd0;
        apple_x   = 7'd60;
        apple_y   = 6'd40;
        query_x   = 7'd9;
        query_y   = 6'd10;

        // rst st tk dv dr | ax ay | qx qy qh | hx hy len stp ate go
        // Plain run to the right.
        vq.push_back(mk(1, 1, 0, 0, 0, 60, 40,  0,  0, 0, 10, 10, 3, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 0, 0, 60, 40,  0,  0, 0, 11, 10, 3, 1, 0, 0));
        vq.push_back(mk(0, 0, 1, 0, 0, 60, 40,  0,  0, 0, 12, 10, 3, 1, 0, 0));
        vq.push_back(mk(0, 0, 1, 0, 0, 60, 40,  0,  0, 0, 13, 10, 3, 1, 0, 0));
        vq.push_back(mk(0, 0, 1, 0, 0, 60, 40, 12, 10, 1, 14, 10, 3, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 60, 40, 11, 10, 0, 14, 10, 3, 0, 0, 0));
        // Eat one apple.
        vq.push_back(mk(1, 1, 0, 0, 0, 12, 10,  0,  0, 0, 10, 10, 3, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 0, 0, 12, 10,  0,  0, 0, 11, 10, 3, 1, 0, 0));
        vq.push_back(mk(0, 0, 1, 0, 0, 12, 10,  9, 10, 1, 12, 10, 4, 1, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 12, 10, 10, 10, 1, 12, 10, 4, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 12, 10,  8, 10, 0, 12, 10, 4, 0, 0, 0));
        // Reversal dropped; request with tick applies to the following move.
        vq.push_back(mk(1, 1, 0, 0, 0, 60, 40,  0,  0, 0, 10, 10, 3, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 3, 60, 40,  0,  0, 0, 10, 10, 3, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 0, 0, 60, 40,  0,  0, 0, 11, 10, 3, 1, 0, 0));
        vq.push_back(mk(0, 0, 1, 1, 0, 60, 40,  0,  0, 0, 12, 10, 3, 1, 0, 0));
        vq.push_back(mk(0, 0, 1, 0, 0, 60, 40,  0,  0, 0, 12,  9, 3, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 2, 60, 40,  0,  0, 0, 12,  9, 3, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 0, 0, 60, 40,  0,  0, 0, 12,  8, 3, 1, 0, 0));
        // Run up into the top wall, tick while dead, restart.
        vq.push_back(mk(1, 1, 0, 0, 0, 60, 40,  0,  0, 0, 10, 10, 3, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 0, 60, 40,  0,  0, 0, 10, 10, 3, 0, 0, 0));
        for (int k = 1; k <= 10; k++) begin
            vq.push_back(mk(0, 0, 1, 0, 0, 60, 40, 0, 0, 0, 10, 10 - k, 3, 1, 0, 0));
        end
        vq.push_back(mk(0, 0, 1, 0, 0, 60, 40,  0,  0, 0, 10,  0, 3, 0, 0, 1));
        vq.push_back(mk(0, 0, 1, 0, 0, 60, 40, 10,  1, 1, 10,  0, 3, 0, 0, 1));
        vq.push_back(mk(0, 1, 0, 0, 0, 60, 40,  8, 10, 1, 10, 10, 3, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 0, 0, 60, 40,  0,  0, 0, 11, 10, 3, 1, 0, 0));

        // Reset state, before any start.
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("rst head_x", int'(hx[0]), 10);
        chk("rst head_y", int'(hy[0]), 10);
        chk("rst length", int'(len[0]), 3);
        chk("rst step", int'(stp[0]), 0);
        chk("rst ate", int'(at[0]), 0);
        chk("rst game_over", int'(go[0]), 0);
        chk("rst query (9,10)", int'(qh[0]), 1);
        query_x = 7'd8;
        #1;
        chk("rst query (8,10) len3", int'(qh[0]), 1);
        query_x = 7'd7;
        #1;
        chk("rst query (7,10) len3", int'(qh[0]), 0);
        chk("rst query (7,10) len5", int'(qh[1]), 1);
        cyc(0, 1, 0, 0);
        chk("idle tick ignored", int'(hx[0]), 10);
        chk("idle tick no step", int'(stp[0]), 0);

        foreach (vq[k]) begin
            v = vq[k];
            if (v.rst != 0) do_reset();
            apple_x = 7'(v.ax);
            apple_y = 6'(v.ay);
            query_x = 7'(v.qx);
            query_y = 6'(v.qy);
            cyc(v.st, v.tk, v.dv, v.dr);
            chk($sformatf("v%0d head_x", k), int'(hx[0]), v.hx);
            chk($sformatf("v%0d head_y", k), int'(hy[0]), v.hy);
            chk($sformatf("v%0d length", k), int'(len[0]), v.len);
            chk($sformatf("v%0d step", k), int'(stp[0]), v.stp);
            chk($sformatf("v%0d ate", k), int'(at[0]), v.at);
            chk($sformatf("v%0d game_over", k), int'(go[0]), v.go);
            chk($sformatf("v%0d query_hit", k), int'(qh[0]), v.qh);
            for (int j = 0; j < 2; j++) begin
                cyc(0, 0, 0, 0);
                chk($sformatf("v%0d gap%0d step", k, j), int'(stp[0]), 0);
                chk($sformatf("v%0d gap%0d ate", k, j), int'(at[0]), 0);
            end
        end

        // Down, left, up back onto (9,10): body for length 5, vacating tail for length 4.
        do_reset();
        apple_x = 7'd60;
        apple_y = 6'd40;
        cyc(1, 0, 0, 0);
        turn_and_tick(2);
        turn_and_tick(3);
        turn_and_tick(0);
        chk("len5 self game_over", int'(go[1]), 1);
        chk("len5 head_x frozen", int'(hx[1]), 9);
        chk("len5 head_y frozen", int'(hy[1]), 11);
        chk("len5 length", int'(len[1]), 5);
        chk("len4 tail legal game_over", int'(go[2]), 0);
        chk("len4 head_x", int'(hx[2]), 9);
        chk("len4 head_y", int'(hy[2]), 10);
        chk("len4 length", int'(len[2]), 4);

        // Saturated length still eats; then asynchronous reset mid-run.
        do_reset();
        apple_x = 7'd11;
        apple_y = 6'd10;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk("max4 apple1 length", int'(len[3]), 4);
        chk("max4 apple1 ate", int'(at[3]), 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        apple_x = 7'd12;
        cyc(0, 1, 0, 0);
        chk("max4 apple2 length", int'(len[3]), 4);
        chk("max4 apple2 ate", int'(at[3]), 1);
        chk("max4 apple2 step", int'(stp[3]), 1);
        chk("max4 apple2 head_x", int'(hx[3]), 12);
        chk("max18 apple2 length", int'(len[0]), 5);
        query_x = 7'd9;
        query_y = 6'd10;
        #1;
        chk("max4 query (9,10)", int'(qh[3]), 1);
        query_x = 7'd8;
        #1;
        chk("max4 query tail dropped", int'(qh[3]), 0);
        chk("max18 query (8,10)", int'(qh[0]), 1);
        reset_n = 1'b0;
        #1;
        chk("async head_x", int'(hx[3]), 10);
        chk("async head_y", int'(hy[3]), 10);
        chk("async length", int'(len[3]), 3);
        chk("async step", int'(stp[3]), 0);
        chk("async ate", int'(at[3]), 0);
        chk("async game_over", int'(go[3]), 0);
        #1;
        reset_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
